// File: rtl/run_monitor_pkg.sv
// Shared types and defaults for the OSECPU run monitor.
// The state and status encodings are kept here so the bench and the RTL use the same names.
package run_monitor_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ST_NONE,
        ST_PASS,
        ST_TIMEOUT,
        ST_MISMATCH
    } status_t;

    localparam int DEF_TIMEOUT  = 100;
    localparam int DEF_RST_HOLD = 2;

endpackage

// File: rtl/run_monitor_if.sv
// Board-side control, CPU-side status and result signals of the run monitor.
// The master modport is the driver of start/expect and of the CPU flags; the slave is the monitor.
interface run_monitor_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic                     start;
    logic                     expect_en;
    logic [DATA_W-1:0]        expect_val;
    logic                     cpu_halt;
    logic signed [DATA_W-1:0] cpu_dr;

    logic                     cpu_reset;
    logic                     busy;
    logic                     done;
    logic                     pass;
    logic                     fail_timeout;
    logic                     fail_mismatch;
    logic [CNT_W-1:0]         cycles;
    logic [DATA_W-1:0]        dr_capt;

    modport master (
        output start, expect_en, expect_val, cpu_halt, cpu_dr,
        input  cpu_reset, busy, done, pass, fail_timeout, fail_mismatch, cycles, dr_capt
    );

    modport slave (
        input  start, expect_en, expect_val, cpu_halt, cpu_dr,
        output cpu_reset, busy, done, pass, fail_timeout, fail_mismatch, cycles, dr_capt
    );
endinterface

// File: rtl/run_monitor_sat_counter.sv
// Up-counter with synchronous clear, enable and saturation at all-ones.
// tc_o compares the current count, so a caller wanting "reaches N on this edge" passes N-1.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] tc_val_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == tc_val_i);
endmodule

// File: rtl/run_monitor.sv
// Run controller/checker for OSECPU: holds the CPU in reset, times the run, checks DR at halt.
// state | meaning: IDLE idle, CPU parked | HOLD CPU reset asserted | RUN counting | DONE result valid, CPU parked
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 32,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int RST_HOLD = DEF_RST_HOLD
) (
    input  logic          clk,
    input  logic          reset,
    run_monitor_if.slave  bus
);
    localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] TO_TC   = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    status_t           status_d;
    logic              go, halt_hit, to_hit, hold_tc, cyc_tc;
    logic [CNT_W-1:0]  hold_cnt_unused;
    logic              cpu_reset_q, cpu_reset_d, busy_q, busy_d, done_q, done_d;
    logic              pass_q, pass_d, fto_q, fto_d, fmm_q, fmm_d;
    logic              exp_en_q, exp_en_d;
    logic [DATA_W-1:0] exp_val_q, exp_val_d, dr_capt_q, dr_capt_d;

    assign go       = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign halt_hit = (state_q == S_RUN) && bus.cpu_halt;
    assign to_hit   = (TIMEOUT != 0) && (state_q == S_RUN) && !bus.cpu_halt && cyc_tc;

    sat_counter #(.W(CNT_W)) u_hold_cnt (
        .clk(clk), .rst_n(reset), .clr_i(go), .en_i(state_q == S_HOLD),
        .tc_val_i(HOLD_TC), .cnt_o(hold_cnt_unused), .tc_o(hold_tc)
    );

    sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk(clk), .rst_n(reset), .clr_i(go), .en_i(state_q == S_RUN),
        .tc_val_i(TO_TC), .cnt_o(bus.cycles), .tc_o(cyc_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fto_q       <= 1'b0;
            fmm_q       <= 1'b0;
            exp_en_q    <= 1'b0;
            exp_val_q   <= '0;
            dr_capt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fto_q       <= fto_d;
            fmm_q       <= fmm_d;
            exp_en_q    <= exp_en_d;
            exp_val_q   <= exp_val_d;
            dr_capt_q   <= dr_capt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (bus.start) state_d = S_HOLD;
            S_HOLD:         if (hold_tc) state_d = S_RUN;
            S_RUN:          if (halt_hit || to_hit) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        status_d = ST_NONE;
        if (halt_hit)
            status_d = (!exp_en_q || (bus.cpu_dr == exp_val_q)) ? ST_PASS : ST_MISMATCH;
        else if (to_hit)
            status_d = ST_TIMEOUT;

        // Registered outputs follow the state being entered so they line up with it.
        cpu_reset_d = (state_d != S_RUN);
        busy_d      = (state_d == S_HOLD) || (state_d == S_RUN);
        done_d      = (state_d == S_DONE);
        pass_d      = pass_q;
        fto_d       = fto_q;
        fmm_d       = fmm_q;
        exp_en_d    = exp_en_q;
        exp_val_d   = exp_val_q;
        dr_capt_d   = dr_capt_q;

        if (go) begin
            pass_d    = 1'b0;
            fto_d     = 1'b0;
            fmm_d     = 1'b0;
            dr_capt_d = '0;
            exp_en_d  = bus.expect_en;
            exp_val_d = bus.expect_val;
        end
        if (halt_hit || to_hit) begin
            pass_d    = (status_d == ST_PASS);
            fto_d     = (status_d == ST_TIMEOUT);
            fmm_d     = (status_d == ST_MISMATCH);
            dr_capt_d = bus.cpu_dr;
        end
    end

    assign bus.cpu_reset     = cpu_reset_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.fail_timeout  = fto_q;
    assign bus.fail_mismatch = fmm_q;
    assign bus.dr_capt       = dr_capt_q;
endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: directed vector table, random runs against a
// behavioural run model, and hand-written reset/saturation sequences.
module tb_run_monitor;
    logic clk;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        bit          en;
        logic [31:0] val;
        int          halt_at;
        logic [31:0] dr;
        bit          noise;
        int          e_cyc;
        bit          e_pass;
        bit          e_to;
        bit          e_mm;
        logic [31:0] e_dr;
    } vec_t;

    vec_t vecs[10];

    run_monitor_if #(.DATA_W(32), .CNT_W(32)) ba ();
    run_monitor_if #(.DATA_W(32), .CNT_W(4))  bb ();

    run_monitor #(.DATA_W(32), .CNT_W(32), .TIMEOUT(100), .RST_HOLD(2)) dut_a (
        .clk(clk), .reset(reset_n), .bus(ba)
    );
    run_monitor #(.DATA_W(32), .CNT_W(4), .TIMEOUT(0), .RST_HOLD(2)) dut_b (
        .clk(clk), .reset(reset_n), .bus(bb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chkw(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chkw(nm, 64'(act), 64'(exp));
    endtask

    // DR value the CPU model presents before RUN edge k.
    function automatic logic [31:0] dval(input vec_t v, input int k);
        if (v.halt_at != 0 && k >= v.halt_at) return v.dr;
        return 32'(v.dr + 32'(k));
    endfunction

    function automatic vec_t model(input vec_t v, input int tmo);
        vec_t r = v;
        bit halted = (v.halt_at != 0) && (v.halt_at <= tmo);
        r.e_cyc  = halted ? v.halt_at : tmo;
        r.e_pass = halted && (!v.en || v.dr == v.val);
        r.e_mm   = halted && v.en && (v.dr != v.val);
        r.e_to   = !halted;
        r.e_dr   = dval(v, r.e_cyc);
        return r;
    endfunction

    function automatic vec_t mkv(bit en, logic [31:0] val, int h, logic [31:0] dr, bit noise,
                                 int ec, bit ep, bit eto, bit emm, logic [31:0] edr);
        vec_t v;
        v.en = en; v.val = val; v.halt_at = h; v.dr = dr; v.noise = noise;
        v.e_cyc = ec; v.e_pass = ep; v.e_to = eto; v.e_mm = emm; v.e_dr = edr;
        return v;
    endfunction

    task automatic run_a(input vec_t v, input string tag);
        int hold_n;
        int k;
        bit seen;
        bit done_in_hold;
        @(negedge clk);
        ba.start = 1'b1; ba.expect_en = v.en; ba.expect_val = v.val;
        ba.cpu_halt = 1'b0; ba.cpu_dr = v.dr;
        @(negedge clk);
        // Expectation inputs change after acceptance; noise runs also pulse start/halt in HOLD.
        ba.start = v.noise; ba.cpu_halt = v.noise;
        ba.expect_en = ~v.en; ba.expect_val = ~v.val;
        hold_n = 0; done_in_hold = 1'b0;
        while (ba.cpu_reset && hold_n < 10) begin
            if (ba.done || !ba.busy) done_in_hold = 1'b1;
            hold_n++;
            @(negedge clk);
        end
        ba.start = 1'b0;
        chkw({tag, "_hold_cycles"}, 64'(hold_n), 64'd2);
        chk1({tag, "_hold_state"}, done_in_hold, 1'b0);
        k = 0; seen = 1'b0;
        while (!seen && k < 300) begin
            k++;
            ba.cpu_halt = (v.halt_at != 0 && k >= v.halt_at);
            ba.cpu_dr = dval(v, k);
            @(negedge clk);
            if (ba.done) seen = 1'b1;
        end
        chk1({tag, "_done_seen"}, seen, 1'b1);
        chkw({tag, "_done_edge"}, 64'(k), 64'(v.e_cyc));
        chkw({tag, "_cycles"}, 64'(ba.cycles), 64'(v.e_cyc));
        chk1({tag, "_pass"}, ba.pass, v.e_pass);
        chk1({tag, "_fail_timeout"}, ba.fail_timeout, v.e_to);
        chk1({tag, "_fail_mismatch"}, ba.fail_mismatch, v.e_mm);
        chkw({tag, "_dr_capt"}, 64'(ba.dr_capt), 64'(v.e_dr));
        chk1({tag, "_cpu_reset"}, ba.cpu_reset, 1'b1);
        chk1({tag, "_busy"}, ba.busy, 1'b0);
        chkw({tag, "_excl"}, 64'(int'(ba.pass) + int'(ba.fail_timeout) + int'(ba.fail_mismatch)), 64'd1);
        // Stale halt stays high in DONE; everything must hold.
        ba.cpu_halt = 1'b1;
        repeat (3) @(negedge clk);
        chk1({tag, "_done_hold"}, ba.done, 1'b1);
        chkw({tag, "_cycles_hold"}, 64'(ba.cycles), 64'(v.e_cyc));
    endtask

    initial begin
        vec_t v;
        int w;
        reset_n = 1'b0;
        ba.start = 1'b0; ba.expect_en = 1'b0; ba.expect_val = '0; ba.cpu_halt = 1'b0; ba.cpu_dr = '0;
        bb.start = 1'b0; bb.expect_en = 1'b0; bb.expect_val = '0; bb.cpu_halt = 1'b0; bb.cpu_dr = '0;

        vecs[0] = mkv(1, 32'hFFFFFFFC, 10,  32'hFFFFFFFC, 0, 10,  1, 0, 0, 32'hFFFFFFFC);
        vecs[1] = mkv(1, 32'hFFFFFFFC, 10,  32'd5,        0, 10,  0, 0, 1, 32'd5);
        vecs[2] = mkv(0, 32'hFFFFFFFC, 10,  32'd5,        0, 10,  1, 0, 0, 32'd5);
        vecs[3] = mkv(1, 32'd0,        0,   32'd7,        0, 100, 0, 1, 0, 32'd107);
        vecs[4] = mkv(1, 32'h1234,     100, 32'h1234,     0, 100, 1, 0, 0, 32'h1234);
        vecs[5] = mkv(1, 32'd1,        1,   32'd1,        1, 1,   1, 0, 0, 32'd1);
        vecs[6] = mkv(1, 32'h80000000, 99,  32'h80000000, 1, 99,  1, 0, 0, 32'h80000000);
        vecs[7] = mkv(1, 32'd3,        101, 32'd3,        0, 100, 0, 1, 0, 32'd103);
        vecs[8] = mkv(1, 32'd5,        40,  32'h80000005, 0, 40,  0, 0, 1, 32'h80000005);
        vecs[9] = mkv(0, 32'd0,        0,   32'hFFFFFFF0, 1, 100, 0, 1, 0, 32'h54);

        #12;
        chk1("rst_cpu_reset", ba.cpu_reset, 1'b1);
        chk1("rst_busy", ba.busy, 1'b0);
        chk1("rst_done", ba.done, 1'b0);
        chkw("rst_flags", 64'({ba.pass, ba.fail_timeout, ba.fail_mismatch}), 64'd0);
        chkw("rst_cycles", 64'(ba.cycles), 64'd0);
        chkw("rst_dr_capt", 64'(ba.dr_capt), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) run_a(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 12; i++) begin
            v.en = 1'($urandom_range(0, 1));
            v.dr = $urandom;
            v.val = ($urandom_range(0, 1) == 1) ? v.dr : $urandom;
            v.halt_at = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 115));
            v.noise = 1'($urandom_range(0, 1));
            v = model(v, 100);
            run_a(v, $sformatf("rnd%0d", i));
        end

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        ba.start = 1'b1; ba.expect_en = 1'b1; ba.expect_val = '0; ba.cpu_halt = 1'b0;
        @(negedge clk);
        ba.start = 1'b0;
        repeat (25) @(negedge clk);
        chk1("mid_busy_before", ba.busy, 1'b1);
        #3 reset_n = 1'b0;
        #1;
        chk1("mid_cpu_reset", ba.cpu_reset, 1'b1);
        chk1("mid_busy", ba.busy, 1'b0);
        chk1("mid_done", ba.done, 1'b0);
        chkw("mid_flags", 64'({ba.pass, ba.fail_timeout, ba.fail_mismatch}), 64'd0);
        chkw("mid_cycles", 64'(ba.cycles), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_a(vecs[0], "post_rst");

        // Narrow counter, no timeout: saturation and ignored start pulses in RUN.
        @(negedge clk);
        bb.start = 1'b1; bb.expect_en = 1'b1; bb.expect_val = 32'h55; bb.cpu_halt = 1'b0; bb.cpu_dr = '0;
        @(negedge clk);
        bb.start = 1'b0;
        w = 0;
        while (bb.cpu_reset && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk1("sat_release", bb.cpu_reset, 1'b0);
        repeat (40) begin
            bb.start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bb.start = 1'b0;
        chkw("sat_cycles", 64'(bb.cycles), 64'd15);
        chk1("sat_busy", bb.busy, 1'b1);
        chk1("sat_done", bb.done, 1'b0);
        bb.cpu_halt = 1'b1; bb.cpu_dr = 32'h55;
        @(negedge clk);
        bb.cpu_halt = 1'b0;
        chk1("sat_halt_done", bb.done, 1'b1);
        chk1("sat_halt_pass", bb.pass, 1'b1);
        chkw("sat_halt_cycles", 64'(bb.cycles), 64'd15);
        chkw("sat_halt_dr", 64'(bb.dr_capt), 64'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
